// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle: pipeline status in, PC/latch controls and status out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             ihit;
  logic             dhit;
  logic             mem_dren;
  logic             mem_dwen;
  logic             halt_mem;
  logic             branch_taken;
  logic             jump_id;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             halted;
  logic [2:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: drives status, consumes controls.
  modport master (
    output ihit, dhit, mem_dren, mem_dwen, halt_mem, branch_taken, jump_id,
           ex_mem_read, ex_rd, id_rs, id_rt, id_uses_rt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted, state, stall_cnt
  );

  // Hazard controller side.
  modport slave (
    input  ihit, dhit, mem_dren, mem_dwen, halt_mem, branch_taken, jump_id,
           ex_mem_read, ex_rd, id_rs, id_rt, id_uses_rt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted, state, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory freezes, branch/jump flushes,
// load-use bubbles, halt, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input logic               CLK,
  input logic               nRST,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEMWAIT  = 3'd1,
    LUBUBBLE = 3'd2,
    HALT     = 3'd3
  } state_e;

  state_e             state_q, state_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic mempend_c, loaduse_c;
  logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
  logic ifid_flush_c, idex_flush_c, exmem_flush_c;

  // Hazard detection terms.
  always_comb begin
    mempend_c = (bus.mem_dren | bus.mem_dwen) & ~bus.dhit;
    loaduse_c = bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                ((bus.ex_rd == bus.id_rs) |
                 (bus.id_uses_rt & (bus.ex_rd == bus.id_rt)));
  end

  // Next state and control outputs; priority chain in RUN/LUBUBBLE.
  always_comb begin
    state_d       = state_q;
    pc_en_c       = 1'b0;
    ifid_en_c     = 1'b0;
    idex_en_c     = 1'b0;
    exmem_en_c    = 1'b0;
    memwb_en_c    = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;
    unique case (state_q)
      RUN, LUBUBBLE: begin
        if (bus.halt_mem) begin
          // Let the halt retire into WB, bubble everything behind it.
          memwb_en_c    = 1'b1;
          exmem_flush_c = 1'b1;
          state_d       = HALT;
        end else if (mempend_c) begin
          state_d = MEMWAIT;
        end else if (bus.branch_taken) begin
          pc_en_c       = 1'b1;
          ifid_en_c     = 1'b1;
          idex_en_c     = 1'b1;
          exmem_en_c    = 1'b1;
          memwb_en_c    = 1'b1;
          ifid_flush_c  = 1'b1;
          idex_flush_c  = 1'b1;
          exmem_flush_c = 1'b1;
          state_d       = RUN;
        end else if (loaduse_c && (state_q == RUN)) begin
          // Hold IF/ID, insert a bubble into ID/EX.
          exmem_en_c   = 1'b1;
          memwb_en_c   = 1'b1;
          idex_flush_c = 1'b1;
          state_d      = LUBUBBLE;
        end else if (bus.jump_id && bus.ihit) begin
          pc_en_c      = 1'b1;
          ifid_en_c    = 1'b1;
          idex_en_c    = 1'b1;
          exmem_en_c   = 1'b1;
          memwb_en_c   = 1'b1;
          ifid_flush_c = 1'b1;
          state_d      = RUN;
        end else if (!bus.ihit) begin
          idex_en_c    = 1'b1;
          exmem_en_c   = 1'b1;
          memwb_en_c   = 1'b1;
          ifid_flush_c = 1'b1;
          state_d      = RUN;
        end else begin
          pc_en_c    = 1'b1;
          ifid_en_c  = 1'b1;
          idex_en_c  = 1'b1;
          exmem_en_c = 1'b1;
          memwb_en_c = 1'b1;
          state_d    = RUN;
        end
      end
      MEMWAIT: begin
        // Halt/branch stay latched in MEM and are seen again once back in RUN.
        if (bus.dhit) begin
          pc_en_c      = bus.ihit;
          ifid_en_c    = bus.ihit;
          idex_en_c    = 1'b1;
          exmem_en_c   = 1'b1;
          memwb_en_c   = 1'b1;
          ifid_flush_c = ~bus.ihit;
          state_d      = RUN;
        end
      end
      HALT: state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // Status register next values; counter saturates instead of wrapping.
  always_comb begin
    halted_d    = (state_d == HALT);
    stall_cnt_d = stall_cnt_q;
    if (!pc_en_c && (state_q != HALT) && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // State and status registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Controls are held inactive for as long as reset is asserted.
  always_comb begin
    bus.pc_en       = pc_en_c       & nRST;
    bus.ifid_en     = ifid_en_c     & nRST;
    bus.idex_en     = idex_en_c     & nRST;
    bus.exmem_en    = exmem_en_c    & nRST;
    bus.memwb_en    = memwb_en_c    & nRST;
    bus.ifid_flush  = ifid_flush_c  & nRST;
    bus.idex_flush  = idex_flush_c  & nRST;
    bus.exmem_flush = exmem_flush_c & nRST;
    bus.halted      = halted_q;
    bus.state       = state_q;
    bus.stall_cnt   = stall_cnt_q;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: main instance plus a 2-bit counter instance.
module tb_pipe_hazard_ctrl;

  logic CLK = 1'b0;
  logic nRST;
  int   n_run  = 0;
  int   n_fail = 0;
  int   exp_sat [6] = '{1, 2, 3, 3, 3, 3};

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl_if #(.CNT_W(16)) h ();
  pipe_hazard_ctrl_if #(.CNT_W(2))  s ();

  pipe_hazard_ctrl #(.CNT_W(16)) dut (.CLK(CLK), .nRST(nRST), .bus(h.slave));
  pipe_hazard_ctrl #(.CNT_W(2))  dut_sat (.CLK(CLK), .nRST(nRST), .bus(s.slave));

  // Controls packed as {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl}.
  function automatic logic [7:0] ctl();
    ctl = {h.pc_en, h.ifid_en, h.idex_en, h.exmem_en, h.memwb_en,
           h.ifid_flush, h.idex_flush, h.exmem_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    h.ihit = 1'b1; h.dhit = 1'b0; h.mem_dren = 1'b0; h.mem_dwen = 1'b0;
    h.halt_mem = 1'b0; h.branch_taken = 1'b0; h.jump_id = 1'b0;
    h.ex_mem_read = 1'b0; h.ex_rd = 5'd0; h.id_rs = 5'd0; h.id_rt = 5'd0;
    h.id_uses_rt = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    chk("rst_ctl",    32'(ctl()),       'h00);
    chk("rst_state",  32'(h.state),     0);
    chk("rst_halted", 32'(h.halted),    0);
    chk("rst_cnt",    32'(h.stall_cnt), 0);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    idle();
    s.ihit = 1'b1; s.dhit = 1'b0; s.mem_dren = 1'b0; s.mem_dwen = 1'b0;
    s.halt_mem = 1'b0; s.branch_taken = 1'b0; s.jump_id = 1'b0;
    s.ex_mem_read = 1'b0; s.ex_rd = 5'd0; s.id_rs = 5'd0; s.id_rt = 5'd0;
    s.id_uses_rt = 1'b0;
    do_reset();

    // Normal flow
    #1; chk("norm_ctl", 32'(ctl()), 'hF8);
    tick(); chk("norm_state", 32'(h.state), 0); chk("norm_cnt", 32'(h.stall_cnt), 0);

    // Load-use on rs: one bubble, LUBUBBLE ignores the still-present match
    h.ex_mem_read = 1'b1; h.ex_rd = 5'd5; h.id_rs = 5'd5;
    #1; chk("lu_ctl", 32'(ctl()), 'h1A);
    tick(); chk("lu_state", 32'(h.state), 2); chk("lu_cnt", 32'(h.stall_cnt), 1);
    #1; chk("lub_ctl", 32'(ctl()), 'hF8);
    tick(); chk("lub_state", 32'(h.state), 0); chk("lub_cnt", 32'(h.stall_cnt), 1);

    // ex_rd = 0 never stalls
    idle(); h.ex_mem_read = 1'b1; h.id_uses_rt = 1'b1;
    #1; chk("rd0_ctl", 32'(ctl()), 'hF8);
    tick(); chk("rd0_state", 32'(h.state), 0);

    // Load-use on rt, then jump with ihit from LUBUBBLE
    idle(); h.ex_mem_read = 1'b1; h.ex_rd = 5'd7; h.id_rt = 5'd7; h.id_rs = 5'd3;
    h.id_uses_rt = 1'b1;
    #1; chk("lurt_ctl", 32'(ctl()), 'h1A);
    tick(); chk("lurt_state", 32'(h.state), 2); chk("lurt_cnt", 32'(h.stall_cnt), 2);
    h.jump_id = 1'b1;
    #1; chk("jmp_ctl", 32'(ctl()), 'hFC);
    tick(); chk("jmp_state", 32'(h.state), 0); chk("jmp_cnt", 32'(h.stall_cnt), 2);

    // rt match but rt unused: no stall
    h.jump_id = 1'b0; h.id_uses_rt = 1'b0;
    #1; chk("nort_ctl", 32'(ctl()), 'hF8);
    tick();

    // Fetch miss, alone and with a jump
    idle(); h.ihit = 1'b0;
    #1; chk("imiss_ctl", 32'(ctl()), 'h3C);
    tick(); chk("imiss_cnt", 32'(h.stall_cnt), 3);
    h.jump_id = 1'b1;
    #1; chk("jmiss_ctl", 32'(ctl()), 'h3C);
    tick(); chk("jmiss_cnt", 32'(h.stall_cnt), 4); chk("jmiss_state", 32'(h.state), 0);

    // Data miss: three frozen cycles, halt ignored in MEMWAIT, release with ihit=0
    idle(); do_reset();
    h.mem_dren = 1'b1; h.ihit = 1'b0;
    #1; chk("mw0_ctl", 32'(ctl()), 'h00);
    tick(); chk("mw0_state", 32'(h.state), 1); chk("mw0_cnt", 32'(h.stall_cnt), 1);
    h.halt_mem = 1'b1;
    #1; chk("mw1_ctl", 32'(ctl()), 'h00);
    tick(); chk("mw1_state", 32'(h.state), 1);
    h.halt_mem = 1'b0;
    #1; chk("mw2_ctl", 32'(ctl()), 'h00);
    tick(); chk("mw2_cnt", 32'(h.stall_cnt), 3);
    h.dhit = 1'b1;
    #1; chk("mwrel_ctl", 32'(ctl()), 'h3C);
    tick(); chk("mwrel_state", 32'(h.state), 0); chk("mwrel_cnt", 32'(h.stall_cnt), 4);

    // Branch beats jump and fetch miss
    idle(); do_reset();
    h.branch_taken = 1'b1; h.ihit = 1'b0; h.jump_id = 1'b1;
    #1; chk("br_ctl", 32'(ctl()), 'hFF);
    tick(); chk("br_state", 32'(h.state), 0); chk("br_cnt", 32'(h.stall_cnt), 0);

    // Reset in MEMWAIT returns to clean RUN
    idle(); h.mem_dren = 1'b1;
    tick(); chk("mwr_state", 32'(h.state), 1);
    idle(); do_reset();
    #1; chk("mwr_ctl", 32'(ctl()), 'hF8);
    tick(); chk("mwr_state2", 32'(h.state), 0);

    // Halt beats load-use; stays halted, counter frozen
    h.ex_mem_read = 1'b1; h.ex_rd = 5'd5; h.id_rs = 5'd5; h.halt_mem = 1'b1;
    #1; chk("halt_ctl", 32'(ctl()), 'h09);
    tick(); chk("halt_state", 32'(h.state), 3); chk("halt_flag", 32'(h.halted), 1);
    chk("halt_cnt", 32'(h.stall_cnt), 1);
    idle(); h.dhit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("hold_ctl", 32'(ctl()), 'h00);
      tick(); chk("hold_flag", 32'(h.halted), 1); chk("hold_cnt", 32'(h.stall_cnt), 1);
    end
    idle(); do_reset();
    tick(); chk("unhalt_state", 32'(h.state), 0); chk("unhalt_flag", 32'(h.halted), 0);

    // 2-bit counter saturation
    s.ihit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(); chk("sat_cnt", 32'(s.stall_cnt), 32'(exp_sat[i]));
    end
    nRST = 1'b0;
    #1; chk("sat_rst_cnt", 32'(s.stall_cnt), 0); chk("sat_rst_state", 32'(s.state), 0);
    @(negedge CLK); nRST = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
